// File: rtl/i2c_simple_slave_pkg.sv
// Shared definitions for the I2C target: state encoding and byte width.
`timescale 1ns/1ps
package i2c_simple_slave_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_ADDR_ACK = 3'd2,
    S_RX       = 3'd3,
    S_RX_ACK   = 3'd4,
    S_TX       = 3'd5,
    S_TX_ACK   = 3'd6,
    S_IGNORE   = 3'd7
  } state_t;

  // States in which a START/STOP landing mid-byte is a protocol error.
  function automatic logic is_shift_state(input state_t s);
    return (s == S_ADDR) || (s == S_RX) || (s == S_TX);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes raw SCL/SDA and derives SCL edges plus START/STOP conditions.
`timescale 1ns/1ps
module i2c_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_di,
  input  logic sda_di,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_sync_q, scl_sync_d;
  logic [1:0] sda_sync_q, sda_sync_d;
  logic       scl_prev_q, scl_prev_d;
  logic       sda_prev_q, sda_prev_d;
  logic       scl_s;

  // Next values of the synchronizer chains and the one-sample history.
  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_di};
    sda_sync_d = {sda_sync_q[0], sda_di};
    scl_prev_d = scl_sync_q[1];
    sda_prev_d = sda_sync_q[1];
  end

  // Idle bus is high, so everything resets to 1 to avoid phantom edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_simple_slave.sv
// Byte-level I2C target with a fixed 7-bit address; per-byte strobes to host logic.
`timescale 1ns/1ps
module i2c_simple_slave
  import i2c_simple_slave_pkg::*;
#(
  parameter logic [6:0] i2c_address = 7'h42
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scl_di,
  input  logic              sda_di,
  output logic              scl_ndo,
  output logic              sda_ndo,
  output logic [BYTE_W-1:0] i2c_data_rd,
  output logic              i2c_data_rd_valid_stb,
  input  logic [BYTE_W-1:0] i2c_data_wr,
  output logic              i2c_data_wr_finish_stb,
  output logic              i2c_error_stb
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync u_line_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_di    (scl_di),
    .sda_di    (sda_di),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_t            state, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic              rise_seen_q, rise_seen_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              rw_q, rw_d;
  logic              mack_q, mack_d;
  logic              sda_q, sda_d;
  logic [BYTE_W-1:0] data_rd_q, data_rd_d;
  logic              rd_stb_q, rd_stb_d;
  logic              fin_stb_q, fin_stb_d;
  logic              err_q, err_d;

  // Protocol FSM; bits are counted on SCL falls that follow a rise, so the
  // fall right after START and the rise belonging to STOP are never counted.
  always_comb begin
    state_d     = state;
    bit_cnt_d   = bit_cnt_q;
    rise_seen_d = rise_seen_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    mack_d      = mack_q;
    sda_d       = sda_q;
    data_rd_d   = data_rd_q;
    rd_stb_d    = 1'b0;
    fin_stb_d   = 1'b0;
    err_d       = 1'b0;

    if (start_det || stop_det) begin
      err_d       = is_shift_state(state) && (bit_cnt_q != 3'd0);
      state_d     = start_det ? S_ADDR : S_IDLE;
      bit_cnt_d   = 3'd0;
      rise_seen_d = 1'b0;
      sda_d       = 1'b0;
    end else if (scl_rise) begin
      rise_seen_d = 1'b1;
      case (state)
        S_ADDR, S_RX: shift_d = {shift_q[BYTE_W-2:0], sda_s};
        S_TX_ACK:     mack_d  = sda_s;
        default:      shift_d = shift_q;
      endcase
    end else if (scl_fall && rise_seen_q) begin
      rise_seen_d = 1'b0;
      case (state)
        S_ADDR: begin
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
            rw_d      = shift_q[0];
            if (shift_q[BYTE_W-1:1] == i2c_address) begin
              state_d = S_ADDR_ACK;
              sda_d   = 1'b1;
            end else begin
              state_d = S_IGNORE;
              sda_d   = 1'b0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        S_ADDR_ACK: begin
          if (rw_q) begin
            shift_d = i2c_data_wr;
            sda_d   = i2c_data_wr[BYTE_W-1];
            state_d = S_TX;
          end else begin
            sda_d   = 1'b0;
            state_d = S_RX;
          end
        end
        S_RX: begin
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
            data_rd_d = shift_q;
            rd_stb_d  = 1'b1;
            sda_d     = 1'b1;
            state_d   = S_RX_ACK;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        S_RX_ACK: begin
          sda_d   = 1'b0;
          state_d = S_RX;
        end
        S_TX: begin
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
            sda_d     = 1'b0;
            state_d   = S_TX_ACK;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {shift_q[BYTE_W-2:0], 1'b0};
            sda_d     = shift_q[BYTE_W-2];
          end
        end
        S_TX_ACK: begin
          fin_stb_d = 1'b1;
          if (!mack_q) begin
            shift_d = i2c_data_wr;
            sda_d   = i2c_data_wr[BYTE_W-1];
            state_d = S_TX;
          end else begin
            sda_d   = 1'b0;
            state_d = S_IGNORE;
          end
        end
        default: state_d = state;
      endcase
    end else begin
      rise_seen_d = rise_seen_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      bit_cnt_q   <= 3'd0;
      rise_seen_q <= 1'b0;
      shift_q     <= 8'h00;
      rw_q        <= 1'b0;
      mack_q      <= 1'b1;
      sda_q       <= 1'b0;
      data_rd_q   <= 8'h00;
      rd_stb_q    <= 1'b0;
      fin_stb_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rise_seen_q <= rise_seen_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      mack_q      <= mack_d;
      sda_q       <= sda_d;
      data_rd_q   <= data_rd_d;
      rd_stb_q    <= rd_stb_d;
      fin_stb_q   <= fin_stb_d;
      err_q       <= err_d;
    end
  end

  assign scl_ndo                = 1'b0;
  assign sda_ndo                = sda_q;
  assign i2c_data_rd            = data_rd_q;
  assign i2c_data_rd_valid_stb  = rd_stb_q;
  assign i2c_data_wr_finish_stb = fin_stb_q;
  assign i2c_error_stb          = err_q;

endmodule

// File: tb/tb_i2c_simple_slave.sv
// Scoreboard bench: stimulus tasks act as I2C master and queue expectations; one monitor checks.
`timescale 1ns/1ps
module tb_i2c_simple_slave;
  import i2c_simple_slave_pkg::*;

  localparam logic [6:0] SLAVE_ADDR = 7'h42;

  logic       clk, rst_n, scl_di, sda_di;
  logic       scl_ndo, sda_ndo;
  logic [7:0] i2c_data_rd, i2c_data_wr;
  logic       i2c_data_rd_valid_stb, i2c_data_wr_finish_stb, i2c_error_stb;

  i2c_simple_slave #(.i2c_address(SLAVE_ADDR)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .scl_di                 (scl_di),
    .sda_di                 (sda_di),
    .scl_ndo                (scl_ndo),
    .sda_ndo                (sda_ndo),
    .i2c_data_rd            (i2c_data_rd),
    .i2c_data_rd_valid_stb  (i2c_data_rd_valid_stb),
    .i2c_data_wr            (i2c_data_wr),
    .i2c_data_wr_finish_stb (i2c_data_wr_finish_stb),
    .i2c_error_stb          (i2c_error_stb)
  );

  // Period 2; edges fall on half units so integer-time input changes never race them.
  initial begin
    clk = 1'b0;
    #1.5;
    forever begin
      clk = ~clk;
      #1;
    end
  end

  typedef struct {
    int         kind;   // 0 reset values, 1 idle, 2 data_rd hold, 3 end
    logic [7:0] val;
  } req_t;

  logic       exp_sda [$];
  logic [7:0] exp_rd  [$];
  logic [7:0] exp_fin [$];
  logic       exp_err [$];
  req_t       req_q   [$];
  logic [7:0] bytes_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: all comparisons happen here, on the falling clock edge.
  logic       scl_prev = 1'b1;
  logic       rd_prev = 1'b0, fin_prev = 1'b0, err_prev = 1'b0;
  logic       e_bit;
  logic [7:0] e_byte;
  req_t       r;

  always @(negedge clk) begin
    if (scl_di && !scl_prev) begin
      check("sda_rise_expected", {31'd0, exp_sda.size() > 0}, 32'd1);
      if (exp_sda.size() > 0) begin
        e_bit = exp_sda.pop_front();
        check("sda_at_scl_rise", {31'd0, sda_ndo}, {31'd0, e_bit});
      end
    end
    if (i2c_data_rd_valid_stb) begin
      check("rd_stb_width", {31'd0, rd_prev}, 32'd0);
      check("rd_stb_expected", {31'd0, exp_rd.size() > 0}, 32'd1);
      if (exp_rd.size() > 0) begin
        e_byte = exp_rd.pop_front();
        check("data_rd", {24'd0, i2c_data_rd}, {24'd0, e_byte});
      end
    end
    if (i2c_data_wr_finish_stb) begin
      check("fin_stb_width", {31'd0, fin_prev}, 32'd0);
      check("fin_stb_expected", {31'd0, exp_fin.size() > 0}, 32'd1);
      if (exp_fin.size() > 0) e_byte = exp_fin.pop_front();
    end
    if (i2c_error_stb) begin
      check("err_stb_width", {31'd0, err_prev}, 32'd0);
      check("err_stb_expected", {31'd0, exp_err.size() > 0}, 32'd1);
      if (exp_err.size() > 0) e_bit = exp_err.pop_front();
    end
    scl_prev <= scl_di;
    rd_prev  <= i2c_data_rd_valid_stb;
    fin_prev <= i2c_data_wr_finish_stb;
    err_prev <= i2c_error_stb;
    while (req_q.size() > 0) begin
      r = req_q.pop_front();
      case (r.kind)
        0: begin
          check("reset_state", {29'd0, dut.state}, {29'd0, S_IDLE});
          check("reset_sda_ndo", {31'd0, sda_ndo}, 32'd0);
          check("reset_scl_ndo", {31'd0, scl_ndo}, 32'd0);
          check("reset_data_rd", {24'd0, i2c_data_rd}, 32'd0);
          check("reset_strobes", {29'd0, i2c_data_rd_valid_stb, i2c_data_wr_finish_stb,
                                  i2c_error_stb}, 32'd0);
        end
        1: begin
          check("idle_after_stop", {29'd0, dut.state}, {29'd0, S_IDLE});
          check("sda_released_idle", {31'd0, sda_ndo}, 32'd0);
          check("scl_ndo_tied", {31'd0, scl_ndo}, 32'd0);
        end
        2: check("data_rd_hold", {24'd0, i2c_data_rd}, {24'd0, r.val});
        default: begin
          check("missing_sda_samples", exp_sda.size(), 32'd0);
          check("missing_rd_stb", exp_rd.size(), 32'd0);
          check("missing_fin_stb", exp_fin.size(), 32'd0);
          check("missing_err_stb", exp_err.size(), 32'd0);
          $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
          $finish;
        end
      endcase
    end
  end

  // ---------------- master-side stimulus ----------------
  task automatic bit_clk(input logic drv, input logic exp);
    exp_sda.push_back(exp);
    #4  sda_di = drv;
    #16 scl_di = 1'b1;
    #10 scl_di = 1'b0;
  endtask

  task automatic send_start();
    sda_di = 1'b1;
    scl_di = 1'b1;
    #10 sda_di = 1'b0;
    #10 scl_di = 1'b0;
  endtask

  task automatic send_stop();
    exp_sda.push_back(1'b0);
    #4  sda_di = 1'b0;
    #16 scl_di = 1'b1;
    #10 sda_di = 1'b1;
    #20 req_q.push_back('{1, 8'h00});
    #10;
  endtask

  task automatic write_txn(input logic [6:0] addr);
    logic match;
    match = (addr == SLAVE_ADDR);
    send_start();
    for (int i = 6; i >= 0; i--) bit_clk(addr[i], 1'b0);
    bit_clk(1'b0, 1'b0);
    bit_clk(1'b1, match);
    for (int k = 0; k < bytes_q.size(); k++) begin
      if (match) exp_rd.push_back(bytes_q[k]);
      for (int i = 7; i >= 0; i--) bit_clk(bytes_q[k][i], 1'b0);
      bit_clk(1'b1, match);
    end
    send_stop();
  endtask

  task automatic read_txn(input logic [6:0] addr);
    logic match, last;
    match = (addr == SLAVE_ADDR);
    send_start();
    for (int i = 6; i >= 0; i--) bit_clk(addr[i], 1'b0);
    bit_clk(1'b1, 1'b0);
    i2c_data_wr = bytes_q[0];
    bit_clk(1'b1, match);
    for (int k = 0; k < bytes_q.size(); k++) begin
      for (int i = 7; i >= 0; i--) bit_clk(1'b1, match & bytes_q[k][i]);
      last = (k == bytes_q.size() - 1);
      i2c_data_wr = last ? 8'($urandom) : bytes_q[k + 1];
      if (match) exp_fin.push_back(bytes_q[k]);
      bit_clk(last, 1'b0);
    end
    send_stop();
  endtask

  initial begin
    logic [6:0] a;
    rst_n = 1'b0;
    scl_di = 1'b1;
    sda_di = 1'b1;
    i2c_data_wr = 8'h00;
    #5 req_q.push_back('{0, 8'h00});
    #5 rst_n = 1'b1;
    #20;

    bytes_q = '{8'h3A};
    write_txn(7'h42);
    bytes_q = '{8'h00};
    write_txn(7'h43);
    req_q.push_back('{2, 8'h3A});
    bytes_q = '{8'h91};
    read_txn(7'h42);
    bytes_q = '{8'h11, 8'h22};
    write_txn(7'h42);
    bytes_q = '{8'($urandom), 8'($urandom)};
    read_txn(7'h42);

    // STOP after three data bits of a write.
    send_start();
    for (int i = 6; i >= 0; i--) bit_clk(SLAVE_ADDR[i], 1'b0);
    bit_clk(1'b0, 1'b0);
    bit_clk(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) bit_clk(1'($urandom), 1'b0);
    exp_err.push_back(1'b1);
    send_stop();

    for (int t = 0; t < 8; t++) begin
      a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : SLAVE_ADDR;
      bytes_q = {};
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) bytes_q.push_back(8'($urandom));
      if ($urandom_range(0, 1) == 0) write_txn(a);
      else read_txn(a);
    end

    req_q.push_back('{3, 8'h00});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
